dff_skid_stage: RTL and testbench

//   Elastic pipeline register with a one-entry skid buffer.

---
 rtl/dff_skid_stage.sv | 88 ++++++++
 tb/tb_dff_skid_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dff_skid_stage.sv
// Elastic DW-bit register stage with a one-entry skid buffer. All outputs are
// registered, so neither the data path nor the ready path is combinational.
module dff_skid_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [1:0]    occ
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          load_main;
  logic          load_skid;
  logic          main_from_skid;
  logic [DW-1:0] skid_p0;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (s_valid) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_valid && m_ready) begin
          load_main = 1'b1;
        end else if (s_valid) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (m_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so any offered beat is left upstream.
        if (m_ready) begin
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control: state and both handshake outputs derive from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      state   <= state_nxt;
      m_valid <= (state_nxt != EMPTY);
      s_ready <= (state_nxt != FULL);
    end
  end

  // Data: main and skid registers carry no reset; validity comes from state.
  always_ff @(posedge clk) begin
    if (load_main) begin
      m_data <= s_data;
    end else if (main_from_skid) begin
      m_data <= skid_p0;
    end
    if (load_skid) begin
      skid_p0 <= s_data;
    end
  end

  assign occ = state;

endmodule

// File: tb/tb_dff_skid_stage.sv
// Bench for dff_skid_stage: directed vector table with explicit expectations,
// backed by a 2-deep FIFO reference model and a random flow-control phase.
module tb_dff_skid_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [1:0]    occ;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] sbq[$];

  typedef struct {
    logic          rst;
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          ev;
    logic          er;
    logic [1:0]    eo;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  dff_skid_stage #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  // One clock: apply inputs, update the reference FIFO, check DUT against it.
  task automatic step(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic          hold;
    logic [DW-1:0] prev;
    int            sz;
    rst     = r;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    hold = (m_valid === 1'b1) && !mr && !r;
    prev = m_data;
    sz   = sbq.size();
    @(posedge clk);
    #1;
    if (r) begin
      sbq.delete();
    end else begin
      if (mr && sz > 0) void'(sbq.pop_front());
      if (sv && sz < 2) sbq.push_back(sd);
    end
    check("model_state", {m_valid, s_ready, occ},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           (sbq.size() != 0), (sbq.size() != 2), 2'(sbq.size())});
    if (sbq.size() != 0) check("model_data", 64'(m_data), 64'(sbq[0]));
    if (hold) check("stall_hold", 64'(m_data), 64'(prev));
  endtask

  initial begin
    // 1. reset with s_valid asserted, then release
    tbl.push_back('{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 32'h0});
    // 2. streaming 1..8 with m_ready held high
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 1'b1, 2'd1, 32'(i)});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
    // 3. stall with A, B, C offered, then release
    tbl.push_back('{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA});
    tbl.push_back('{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
    tbl.push_back('{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
    tbl.push_back('{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB});
    tbl.push_back('{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 2'd1, 32'hC});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
    // 5. fill to FULL, then drain with s_valid low
    tbl.push_back('{1'b0, 1'b1, 32'hD, 1'b0, 1'b1, 1'b1, 2'd1, 32'hD});
    tbl.push_back('{1'b0, 1'b1, 32'hE, 1'b0, 1'b1, 1'b0, 2'd2, 32'hD});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'hE});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
    // 6. reset while FULL; held beats must never reappear
    tbl.push_back('{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11});
    tbl.push_back('{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11});
    tbl.push_back('{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 2'd1, 32'h33});
    tbl.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h0});

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].er));
      check($sformatf("vec%0d_occ", i), 64'(occ), 64'(tbl[i].eo));
      if (tbl[i].ev) check($sformatf("vec%0d_m_data", i), 64'(m_data), 64'(tbl[i].ed));
    end

    // 4. random flow control on both sides
    for (int c = 0; c < 10000; c++)
      step(1'b0, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
    for (int c = 0; c < 4; c++)
      step(1'b0, 1'b0, 32'h0, 1'b1);
    check("final_empty", 64'(occ), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
